// File: rtl/time_date_setter.sv
// Push-button time/date setter: debounced buttons, six-field edit FSM, shadow registers, commit strobe.
// Define EDIT_TIMEOUT_EN to build the inactivity timer that abandons an edit after TIMEOUT_CYCLES.

module time_date_setter_debounce #(
    parameter int unsigned CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);
    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CYCLES - 1);

    logic sync1_q, sync1_d, sync2_q, sync2_d;
    logic level_q, level_d, level_dly_q, level_dly_d, press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d     = btn_n;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        // Down-counter only runs while the synchronized sample disagrees with the accepted level
        if (sync2_q == level_q) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            level_d = sync2_q;
            cnt_d   = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
        level_dly_d = level_q;
        press_d     = level_dly_q & ~level_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            press_q     <= 1'b0;
            cnt_q       <= RELOAD;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

module time_date_setter #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned BLINK_HALF_CYCLES = 12500000,
    parameter int unsigned TIMEOUT_CYCLES    = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [5:0] cur_second,
    input  logic [5:0] cur_minute,
    input  logic [4:0] cur_hour,
    input  logic [4:0] cur_day,
    input  logic [3:0] cur_month,
    input  logic [6:0] cur_year,
    output logic [5:0] set_second,
    output logic [5:0] set_minute,
    output logic [4:0] set_hour,
    output logic [4:0] set_day,
    output logic [3:0] set_month,
    output logic [6:0] set_year,
    output logic       load,
    output logic       editing,
    output logic [2:0] field_sel,
    output logic       blink
);
    // state      | meaning
    // IDLE       | not editing, counters run freely
    // EDIT_HOUR  | inc bumps shadow hour
    // EDIT_MIN   | inc bumps shadow minute
    // EDIT_SEC   | inc bumps shadow second
    // EDIT_YEAR  | inc bumps shadow year
    // EDIT_MONTH | inc bumps shadow month
    // EDIT_DAY   | inc bumps shadow day (wraps at month length)
    // COMMIT     | one-cycle load strobe, then IDLE
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] EDIT_HOUR  = 3'd1;
    localparam logic [2:0] EDIT_MIN   = 3'd2;
    localparam logic [2:0] EDIT_SEC   = 3'd3;
    localparam logic [2:0] EDIT_YEAR  = 3'd4;
    localparam logic [2:0] EDIT_MONTH = 3'd5;
    localparam logic [2:0] EDIT_DAY   = 3'd6;
    localparam logic [2:0] COMMIT     = 3'd7;

    localparam int unsigned BW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_HALF_CYCLES - 1);

    logic mode_press, inc_press, is_edit, timeout_hit;
    logic [2:0] state_q, state_d;
    logic [4:0] hour_q, hour_d, day_q, day_d, maxday;
    logic [5:0] min_q, min_d, sec_q, sec_d;
    logic [6:0] year_q, year_d;
    logic [3:0] month_q, month_d;
    logic blink_q, blink_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;

    time_date_setter_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .reset(reset), .btn_n(btn_mode), .press(mode_press));
    time_date_setter_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .reset(reset), .btn_n(btn_inc), .press(inc_press));

    assign is_edit = (state_q != IDLE) && (state_q != COMMIT);

    always_comb begin
        case (month_q)
            4'd4, 4'd6, 4'd9, 4'd11: maxday = 5'd30;
            4'd2:                    maxday = (year_q[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 maxday = 5'd31;
        endcase
    end

`ifdef EDIT_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_RELOAD = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!is_edit || mode_press || inc_press) begin
            to_cnt_d = TO_RELOAD;
        end else if (to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - 1'b1;
        end
    end

    assign timeout_hit = is_edit && (to_cnt_q == '0) && !mode_press && !inc_press;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) to_cnt_q <= TO_RELOAD;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        year_d  = year_q;
        month_d = month_q;
        day_d   = day_q;
        if (state_q == COMMIT) begin
            state_d = IDLE;
        end else if (mode_press) begin
            case (state_q)
                IDLE: begin
                    hour_d  = cur_hour;
                    min_d   = cur_minute;
                    sec_d   = cur_second;
                    year_d  = cur_year;
                    month_d = cur_month;
                    day_d   = cur_day;
                    state_d = EDIT_HOUR;
                end
                EDIT_HOUR:  state_d = EDIT_MIN;
                EDIT_MIN:   state_d = EDIT_SEC;
                EDIT_SEC:   state_d = EDIT_YEAR;
                EDIT_YEAR:  state_d = EDIT_MONTH;
                EDIT_MONTH: begin
                    // Month/year are final here, so an impossible day is fixed up on entry
                    state_d = EDIT_DAY;
                    if (day_q > maxday) day_d = maxday;
                end
                EDIT_DAY:   state_d = COMMIT;
                default:    state_d = state_q;
            endcase
        end else if (inc_press) begin
            case (state_q)
                EDIT_HOUR:  hour_d  = (hour_q  >= 5'd23) ? 5'd0 : hour_q + 5'd1;
                EDIT_MIN:   min_d   = (min_q   >= 6'd59) ? 6'd0 : min_q + 6'd1;
                EDIT_SEC:   sec_d   = (sec_q   >= 6'd59) ? 6'd0 : sec_q + 6'd1;
                EDIT_YEAR:  year_d  = (year_q  >= 7'd99) ? 7'd0 : year_q + 7'd1;
                EDIT_MONTH: month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
                EDIT_DAY:   day_d   = (day_q >= maxday)  ? 5'd1 : day_q + 5'd1;
                default:    ;
            endcase
        end else if (timeout_hit) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (!is_edit || (state_d != state_q) || inc_press) begin
            blink_d     = 1'b0;
            blink_cnt_d = BLINK_RELOAD;
        end else if (blink_cnt_q == '0) begin
            blink_d     = ~blink_q;
            blink_cnt_d = BLINK_RELOAD;
        end else begin
            blink_cnt_d = blink_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hour_q      <= 5'd0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            year_q      <= 7'd0;
            month_q     <= 4'd1;
            day_q       <= 5'd1;
            blink_q     <= 1'b0;
            blink_cnt_q <= BLINK_RELOAD;
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            year_q      <= year_d;
            month_q     <= month_d;
            day_q       <= day_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign set_hour   = hour_q;
    assign set_minute = min_q;
    assign set_second = sec_q;
    assign set_year   = year_q;
    assign set_month  = month_q;
    assign set_day    = day_q;
    assign load       = (state_q == COMMIT);
    assign editing    = is_edit;
    assign field_sel  = is_edit ? state_q : 3'd0;
    assign blink      = blink_q;
endmodule

// File: tb/tb_time_date_setter.sv
// Self-checking bench for time_date_setter with a calendar-level reference model.
module tb_time_date_setter;
    localparam int D = 4;
    localparam int B = 8;
    localparam int T = 100;

    logic clk = 1'b0, reset = 1'b0, btn_mode = 1'b1, btn_inc = 1'b1;
    logic [5:0] cur_second = '0, cur_minute = '0;
    logic [4:0] cur_hour = '0, cur_day = 5'd1;
    logic [3:0] cur_month = 4'd1;
    logic [6:0] cur_year = '0;
    logic [5:0] set_second, set_minute;
    logic [4:0] set_hour, set_day;
    logic [3:0] set_month;
    logic [6:0] set_year;
    logic load, editing, blink;
    logic [2:0] field_sel;

    time_date_setter #(.DEBOUNCE_CYCLES(D), .BLINK_HALF_CYCLES(B), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_second(cur_second), .cur_minute(cur_minute), .cur_hour(cur_hour),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .set_second(set_second), .set_minute(set_minute), .set_hour(set_hour),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .load(load), .editing(editing), .field_sel(field_sel), .blink(blink));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, load_cnt = 0;
    logic [32:0] load_cap = '0;
    int mh, mmin, ms, my, mmo, md, fsel;
    wire [32:0] dut_vec = {set_hour, set_minute, set_second, set_year, set_month, set_day};
    localparam logic [32:0] RESET_VEC = {5'd0, 6'd0, 6'd0, 7'd0, 4'd1, 5'd1};

    always @(negedge clk) if (load) begin
        load_cnt <= load_cnt + 1;
        load_cap <= dut_vec;
    end

    function automatic int maxday(int m, int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [32:0] model_vec();
        return {5'(mh), 6'(mmin), 6'(ms), 7'(my), 4'(mmo), 5'(md)};
    endfunction

    function automatic void model_reset();
        mh = 0; mmin = 0; ms = 0; my = 0; mmo = 1; md = 1; fsel = 0;
    endfunction

    function automatic void model_mode();
        case (fsel)
            0: begin
                mh = cur_hour; mmin = cur_minute; ms = cur_second;
                my = cur_year; mmo = cur_month; md = cur_day; fsel = 1;
            end
            5: begin
                fsel = 6;
                if (md > maxday(mmo, my)) md = maxday(mmo, my);
            end
            6: fsel = 0;
            default: fsel = fsel + 1;
        endcase
    endfunction

    function automatic void model_inc();
        case (fsel)
            1: mh = (mh + 1) % 24;
            2: mmin = (mmin + 1) % 60;
            3: ms = (ms + 1) % 60;
            4: my = (my + 1) % 100;
            5: mmo = mmo % 12 + 1;
            6: md = md % maxday(mmo, my) + 1;
            default: ;
        endcase
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; btn_mode = 1'b1; btn_inc = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    // Holds the button(s) long enough for one event and lets the release settle.
    task automatic press(input bit m, input bit i);
        @(posedge clk); #1;
        if (m) btn_mode = 1'b0;
        if (i) btn_inc = 1'b0;
        repeat (D + 2) @(posedge clk);
        #1 btn_mode = 1'b1; btn_inc = 1'b1;
        repeat (D + 6) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (dut_vec !== RESET_VEC) begin failures++; $display("FAIL reset_vec got=%h exp=%h", dut_vec, RESET_VEC); end
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", load); end
        checks++; if (editing !== 1'b0) begin failures++; $display("FAIL reset_editing got=%b exp=0", editing); end
        checks++; if (field_sel !== 3'd0) begin failures++; $display("FAIL reset_field got=%0d exp=0", field_sel); end
        checks++; if (blink !== 1'b0) begin failures++; $display("FAIL reset_blink got=%b exp=0", blink); end
        @(posedge clk); #1 reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_debounce();
        @(posedge clk); #1 btn_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 btn_mode = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        checks++; if (editing !== 1'b0) begin failures++; $display("FAIL glitch_editing got=%b exp=0", editing); end
        @(posedge clk); #1 btn_mode = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (k == 9) btn_mode = 1'b1;
            @(negedge clk);
            checks++;
            if (editing !== (k >= 7)) begin failures++; $display("FAIL latency_editing k=%0d got=%b exp=%b", k, editing, k >= 7); end
            if (k == 7) begin
                checks++; if (field_sel !== 3'd1) begin failures++; $display("FAIL latency_field got=%0d exp=1", field_sel); end
            end
        end
        repeat (D + 6) @(posedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        cur_hour = 5'd23; cur_minute = 6'd59; cur_second = 6'd58;
        cur_day = 5'd31; cur_month = 4'd12; cur_year = 7'd99;
        press(1, 0); model_mode();
        checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL snapshot got=%h exp=%h", dut_vec, model_vec()); end
        cur_hour = 5'd3; cur_day = 5'd7;
        press(0, 1); model_inc();
        checks++; if (set_hour !== 5'd0) begin failures++; $display("FAIL hour_wrap got=%0d exp=0", set_hour); end
        press(1, 0); model_mode();
        press(0, 1); model_inc();
        checks++; if (set_minute !== 6'd0) begin failures++; $display("FAIL minute_wrap got=%0d exp=0", set_minute); end
        press(1, 0); model_mode();
        for (int i = 0; i < 2; i++) begin press(0, 1); model_inc(); end
        press(1, 0); model_mode(); press(0, 1); model_inc();
        press(1, 0); model_mode(); press(0, 1); model_inc();
        press(1, 0); model_mode(); press(0, 1); model_inc();
        checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL all_wrap got=%h exp=%h", dut_vec, model_vec()); end
    endtask

    task automatic test_maxday();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            cur_hour = 5'($urandom_range(0, 23)); cur_minute = 6'($urandom_range(0, 59));
            cur_second = 6'($urandom_range(0, 59));
            cur_month = 4'd2; cur_day = 5'd31; cur_year = (pass == 0) ? 7'd24 : 7'd23;
            for (int i = 0; i < 6; i++) begin press(1, 0); model_mode(); end
            checks++; if (field_sel !== 3'd6) begin failures++; $display("FAIL clamp_field got=%0d exp=6", field_sel); end
            checks++;
            if (set_day !== ((pass == 0) ? 5'd29 : 5'd28)) begin
                failures++; $display("FAIL clamp_day got=%0d exp=%0d", set_day, (pass == 0) ? 29 : 28);
            end
        end
        press(0, 1); model_inc();
        checks++; if (set_day !== 5'd1) begin failures++; $display("FAIL feb_day_wrap got=%0d exp=1", set_day); end
        checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL feb_vec got=%h exp=%h", dut_vec, model_vec()); end
    endtask

    task automatic test_random_walk();
        int lc;
        do_reset();
        for (int it = 0; it < 3; it++) begin
            cur_hour = 5'($urandom_range(0, 23)); cur_minute = 6'($urandom_range(0, 59));
            cur_second = 6'($urandom_range(0, 59)); cur_year = 7'($urandom_range(0, 99));
            cur_month = 4'($urandom_range(1, 12)); cur_day = 5'($urandom_range(1, 31));
            press(1, 0); model_mode();
            checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL walk_snap it=%0d got=%h exp=%h", it, dut_vec, model_vec()); end
            cur_hour = 5'($urandom_range(0, 23)); cur_day = 5'($urandom_range(1, 31));
            for (int f = 1; f <= 6; f++) begin
                for (int n = $urandom_range(0, 5); n > 0; n--) begin press(0, 1); model_inc(); end
                checks++;
                if (dut_vec !== model_vec() || field_sel !== 3'(f)) begin
                    failures++; $display("FAIL walk_field f=%0d got=%h/%0d exp=%h/%0d", f, dut_vec, field_sel, model_vec(), f);
                end
                lc = load_cnt;
                press(1, 0); model_mode();
                if (f < 6) begin
                    checks++; if (load_cnt !== lc) begin failures++; $display("FAIL walk_early_load got=%0d exp=%0d", load_cnt - lc, 0); end
                end
            end
            checks++; if (load_cnt - lc !== 1) begin failures++; $display("FAIL commit_load_cycles got=%0d exp=1", load_cnt - lc); end
            checks++; if (load_cap !== model_vec()) begin failures++; $display("FAIL commit_values got=%h exp=%h", load_cap, model_vec()); end
            checks++;
            if (editing !== 1'b0 || field_sel !== 3'd0) begin
                failures++; $display("FAIL commit_idle got=%b/%0d exp=0/0", editing, field_sel);
            end
        end
    endtask

    task automatic test_mode_inc_same();
        do_reset();
        cur_minute = 6'($urandom_range(0, 59));
        press(1, 0); model_mode();
        press(1, 0); model_mode();
        press(1, 1); model_mode();
        checks++; if (field_sel !== 3'd3) begin failures++; $display("FAIL same_field got=%0d exp=3", field_sel); end
        checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL same_minute got=%h exp=%h", dut_vec, model_vec()); end
    endtask

    task automatic test_blink();
        do_reset();
        press(1, 0); model_mode();
        @(posedge clk); #1 btn_inc = 1'b0;
        for (int k = 0; k < 7 + 3 * B; k++) begin
            @(posedge clk); #1;
            if (k == 5) btn_inc = 1'b1;
            @(negedge clk);
            if (k >= 7) begin
                checks++;
                if (blink !== 1'(((k - 7) / B) % 2)) begin
                    failures++; $display("FAIL blink k=%0d got=%b exp=%0d", k, blink, ((k - 7) / B) % 2);
                end
            end
        end
        model_inc();
        checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL blink_inc got=%h exp=%h", dut_vec, model_vec()); end
    endtask

    task automatic test_reset_mid_edit();
        int lc;
        do_reset();
        cur_year = 7'd50;
        for (int i = 0; i < 4; i++) begin press(1, 0); model_mode(); end
        press(0, 1);
        lc = load_cnt;
        @(posedge clk); #3 reset = 1'b0;
        #1;
        checks++; if (dut_vec !== RESET_VEC) begin failures++; $display("FAIL midreset_vec got=%h exp=%h", dut_vec, RESET_VEC); end
        checks++;
        if (editing !== 1'b0 || field_sel !== 3'd0 || load !== 1'b0 || blink !== 1'b0) begin
            failures++; $display("FAIL midreset_ctrl got=%b%0d%b%b exp=0000", editing, field_sel, load, blink);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (load_cnt !== lc) begin failures++; $display("FAIL midreset_load got=%0d exp=%0d", load_cnt, lc); end
    endtask

    task automatic test_timeout();
        int lc;
        do_reset();
        cur_hour = 5'd12;
        lc = load_cnt;
`ifdef EDIT_TIMEOUT_EN
        begin
            bit got;
            int n;
            got = 1'b0; n = 0;
            @(posedge clk); #1 btn_mode = 1'b0;
            repeat (D + 2) @(posedge clk);
            #1 btn_mode = 1'b1;
            for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (editing) got = 1'b1; end
            model_mode();
            while (got && editing && n < 300) begin @(negedge clk); n++; end
            checks++; if (!got || n !== T) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, T); end
            checks++; if (load_cnt !== lc) begin failures++; $display("FAIL timeout_load got=%0d exp=%0d", load_cnt, lc); end
            checks++; if (dut_vec !== model_vec()) begin failures++; $display("FAIL timeout_shadow got=%h exp=%h", dut_vec, model_vec()); end
        end
`else
        press(1, 0); model_mode();
        repeat (1000) @(posedge clk);
        @(negedge clk);
        checks++;
        if (editing !== 1'b1 || field_sel !== 3'd1) begin
            failures++; $display("FAIL no_timeout got=%b/%0d exp=1/1", editing, field_sel);
        end
        checks++; if (load_cnt !== lc) begin failures++; $display("FAIL no_timeout_load got=%0d exp=%0d", load_cnt, lc); end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_debounce();
        test_wrap();
        test_maxday();
        test_random_walk();
        test_mode_inc_same();
        test_blink();
        test_reset_mid_edit();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
